// File: rtl/sqrt_share_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the shared sqrt arbiter.
// The arbiter connects through the slave modport; clients/engine use master.
interface sqrt_share_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int RES_W   = 16
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [RES_W-1:0]          rsp_data;
   logic                      rsp_err;
   logic                      busy;
   logic                      eng_start;
   logic [DATA_W-1:0]         eng_operand;
   logic                      eng_done;
   logic [RES_W-1:0]          eng_result;

   modport slave (
      input  req, req_data, eng_done, eng_result,
      output gnt, rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_operand
   );

   modport master (
      output req, req_data, eng_done, eng_result,
      input  gnt, rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_operand
   );
endinterface

// File: rtl/sqrt_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative square-root engine among
// NUM_REQ requesters. One operation in flight at a time; a watchdog turns a
// missing engine done into an error response. Every output is a flop.
module sqrt_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int RES_W   = 16,
   parameter int TIMEOUT = 64
) (
   input logic                 clk,
   input logic                 rst_n,
   sqrt_share_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t state_reg, state_next;

   logic [PTR_W-1:0]   ptr_reg, ptr_next;
   logic [PTR_W-1:0]   owner_reg, owner_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [NUM_REQ-1:0] gnt_reg, gnt_next;
   logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;
   logic [RES_W-1:0]   rsp_data_reg, rsp_data_next;
   logic               rsp_err_reg, rsp_err_next;
   logic               busy_reg, busy_next;
   logic               eng_start_reg, eng_start_next;
   logic [DATA_W-1:0]  eng_operand_reg, eng_operand_next;

   logic               win_found;
   logic [PTR_W-1:0]   win_idx;

   // Round-robin search starting at ptr; scanning offsets from high to low
   // lets the lowest offset (closest to ptr) overwrite and win.
   always_comb begin
      int               cand;
      logic [PTR_W-1:0] cidx;
      win_found = 1'b0;
      win_idx   = ptr_reg;
      cand      = 0;
      cidx      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = int'(ptr_reg) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cidx = PTR_W'(cand);
         if (bus.req[cidx]) begin
            win_found = 1'b1;
            win_idx   = cidx;
         end
      end
   end

   // State and registered-output flops; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         ptr_reg         <= '0;
         owner_reg       <= '0;
         cnt_reg         <= '0;
         gnt_reg         <= '0;
         rsp_valid_reg   <= '0;
         rsp_data_reg    <= '0;
         rsp_err_reg     <= 1'b0;
         busy_reg        <= 1'b0;
         eng_start_reg   <= 1'b0;
         eng_operand_reg <= '0;
      end else begin
         state_reg       <= state_next;
         ptr_reg         <= ptr_next;
         owner_reg       <= owner_next;
         cnt_reg         <= cnt_next;
         gnt_reg         <= gnt_next;
         rsp_valid_reg   <= rsp_valid_next;
         rsp_data_reg    <= rsp_data_next;
         rsp_err_reg     <= rsp_err_next;
         busy_reg        <= busy_next;
         eng_start_reg   <= eng_start_next;
         eng_operand_reg <= eng_operand_next;
      end
   end

   // Next-state logic; engine done wins over the watchdog on the same cycle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (win_found) state_next = ISSUE;
         ISSUE: state_next = WAIT;
         WAIT:  if (bus.eng_done || (cnt_reg == CNT_LAST)) state_next = RESP;
         RESP:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Next values for datapath registers and the registered outputs.
   always_comb begin
      ptr_next         = ptr_reg;
      owner_next       = owner_reg;
      cnt_next         = cnt_reg;
      gnt_next         = '0;
      rsp_valid_next   = '0;
      rsp_data_next    = rsp_data_reg;
      rsp_err_next     = rsp_err_reg;
      busy_next        = (state_next != IDLE);
      eng_start_next   = 1'b0;
      eng_operand_next = eng_operand_reg;
      case (state_reg)
         IDLE: begin
            if (win_found) begin
               owner_next        = win_idx;
               eng_operand_next  = bus.req_data[win_idx*DATA_W +: DATA_W];
               gnt_next[win_idx] = 1'b1;
            end
         end
         ISSUE: begin
            eng_start_next = 1'b1;
            cnt_next       = '0;
         end
         WAIT: begin
            if (bus.eng_done) begin
               rsp_data_next             = bus.eng_result;
               rsp_err_next              = 1'b0;
               rsp_valid_next[owner_reg] = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
               rsp_data_next             = '0;
               rsp_err_next              = 1'b1;
               rsp_valid_next[owner_reg] = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RESP: begin
            ptr_next = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.gnt         = gnt_reg;
   assign bus.rsp_valid   = rsp_valid_reg;
   assign bus.rsp_data    = rsp_data_reg;
   assign bus.rsp_err     = rsp_err_reg;
   assign bus.busy        = busy_reg;
   assign bus.eng_start   = eng_start_reg;
   assign bus.eng_operand = eng_operand_reg;
endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Directed bench for sqrt_share_arbiter: the engine is played by the stimulus
// sequence itself, and all expected results are hand-computed constants.
module tb_sqrt_share_arbiter;
   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int RES_W   = 16;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst_n;
   int   n_assert = 0;
   int   n_fail   = 0;

   sqrt_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

   sqrt_share_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full operation for requester idx whose req is already high.
   // done_at: cycle (counted from the eng_start cycle) on which eng_done is
   // driven high; 0 means the engine never answers.
   task automatic serve(input string tag, input int idx, input logic [7:0] op,
                        input int done_at, input logic [15:0] res, input int exp_cnt,
                        input logic exp_err, input logic [15:0] exp_data,
                        input bit drop, input bit stray);
      int w;
      int c;
      logic [3:0] oh;
      oh = 4'b0001 << idx;
      bus.eng_result = res;
      w = 0;
      do begin tick(); w++; end while (bus.gnt == '0 && w < 10);
      chk({tag, ".gnt_lat"}, w, 1);
      chk({tag, ".gnt"}, bus.gnt, oh);
      chk({tag, ".operand"}, bus.eng_operand, op);
      chk({tag, ".busy"}, bus.busy, 1);
      bus.eng_done = stray;      // lands in ISSUE and must be ignored
      tick();
      bus.eng_done = 1'b0;
      chk({tag, ".start"}, bus.eng_start, 1);
      chk({tag, ".gnt_clr"}, bus.gnt, 0);
      c = 0;
      do begin
         c++;
         bus.eng_done = (c == done_at);
         tick();
         bus.eng_done = 1'b0;
      end while (bus.rsp_valid == '0 && c < TIMEOUT + 4);
      chk({tag, ".rsp_lat"}, c, exp_cnt);
      chk({tag, ".rsp_valid"}, bus.rsp_valid, oh);
      chk({tag, ".rsp_data"}, bus.rsp_data, exp_data);
      chk({tag, ".rsp_err"}, bus.rsp_err, exp_err);
      $display("txn %s: req %0d op %0d rsp_data %h rsp_err %b", tag, idx, op, bus.rsp_data, bus.rsp_err);
      if (drop) bus.req[idx] = 1'b0;
      tick();
      chk({tag, ".rsp_clr"}, bus.rsp_valid, 0);
      chk({tag, ".hold"}, bus.rsp_data, exp_data);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".gnt"}, bus.gnt, 0);
      chk({tag, ".rsp_valid"}, bus.rsp_valid, 0);
      chk({tag, ".rsp_data"}, bus.rsp_data, 0);
      chk({tag, ".rsp_err"}, bus.rsp_err, 0);
      chk({tag, ".busy"}, bus.busy, 0);
      chk({tag, ".eng_start"}, bus.eng_start, 0);
      chk({tag, ".eng_operand"}, bus.eng_operand, 0);
   endtask

   initial begin
      int w;
      rst_n          = 1'b0;
      bus.req        = '0;
      bus.req_data   = '0;
      bus.eng_done   = 1'b0;
      bus.eng_result = '0;
      tick();
      tick();
      chk_all_zero("reset");

      // All four requesters, served 0,1,2,3
      bus.req_data = {8'd16, 8'd9, 8'd4, 8'd2};
      bus.req      = 4'hF;
      rst_n        = 1'b1;
      serve("all0", 0, 8'd2,  3, 16'h0016, 3, 1'b0, 16'h0016, 1, 0);
      serve("all1", 1, 8'd4,  4, 16'h0020, 4, 1'b0, 16'h0020, 1, 0);
      serve("all2", 2, 8'd9,  2, 16'h0030, 2, 1'b0, 16'h0030, 1, 1);
      serve("all3", 3, 8'd16, 6, 16'h0040, 6, 1'b0, 16'h0040, 1, 0);

      // Single request, engine answers after 5 cycles
      bus.req_data[7:0] = 8'd49;
      bus.req = 4'b0001;
      serve("single", 0, 8'd49, 5, 16'h0070, 5, 1'b0, 16'h0070, 1, 0);

      // Serve 1 (ptr becomes 2), then 3 must beat 0
      bus.req_data[15:8] = 8'd25;
      bus.req = 4'b0010;
      serve("wrap1", 1, 8'd25, 3, 16'h0050, 3, 1'b0, 16'h0050, 1, 0);
      bus.req_data[7:0]   = 8'd36;
      bus.req_data[31:24] = 8'd81;
      bus.req = 4'b1001;
      serve("wrap3", 3, 8'd81, 3, 16'h0090, 3, 1'b0, 16'h0090, 1, 0);
      serve("wrap0", 0, 8'd36, 3, 16'h0060, 3, 1'b0, 16'h0060, 1, 0);

      // Engine never answers: watchdog error after TIMEOUT cycles
      bus.req_data[15:8] = 8'd200;
      bus.req = 4'b0010;
      serve("tmo", 1, 8'd200, 0, 16'hDEAD, TIMEOUT, 1'b1, 16'h0000, 1, 0);
      for (int i = 0; i < 3; i++) begin
         bus.eng_done = 1'b1;    // late done while idle
         tick();
         bus.eng_done = 1'b0;
         chk("late_done.rsp_valid", bus.rsp_valid, 0);
         chk("late_done.busy", bus.busy, 0);
      end

      // Done on the timeout cycle wins
      bus.req_data[23:16] = 8'd100;
      bus.req = 4'b0100;
      serve("tmo_done", 2, 8'd100, TIMEOUT, 16'h00A0, TIMEOUT, 1'b0, 16'h00A0, 1, 0);

      // Reset in WAIT: outputs cleared at once, no response, ptr back to 0
      bus.req_data[31:24] = 8'd121;
      bus.req = 4'b1000;
      w = 0;
      do begin tick(); w++; end while (bus.gnt == '0 && w < 10);
      chk("rst.gnt", bus.gnt, 4'b1000);
      tick();
      chk("rst.start", bus.eng_start, 1);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_async");
      bus.eng_done   = 1'b1;
      bus.eng_result = 16'h1234;
      tick();
      bus.eng_done = 1'b0;
      chk("rst_hold.rsp_valid", bus.rsp_valid, 0);
      chk("rst_hold.busy", bus.busy, 0);
      bus.req_data[15:8] = 8'd64;
      bus.req = 4'b1010;
      rst_n   = 1'b1;
      serve("rst1", 1, 8'd64,  3, 16'h0080, 3, 1'b0, 16'h0080, 1, 0);
      serve("rst3", 3, 8'd121, 3, 16'h00B0, 3, 1'b0, 16'h00B0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
